// File: rtl/i2s_pkg.sv
// Shared I2S audio types: sample width, slot width and the stereo pair carried
// between the receiver, the equaliser datapath and the transmitter.
package i2s_pkg;
    localparam int SAMPLE_W = 24;
    localparam int SLOT_W   = 32;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;
endpackage

// File: rtl/i2s_clkgen.sv
// I2S master clock generator: divides clk into bck, tracks the bit position in
// the 2*SLOT_W-bit frame, drives lrck and strobes each bck falling edge.
module i2s_clkgen #(
    parameter int SLOT_W   = 32,
    parameter int BCK_HALF = 2,
    localparam int BW      = $clog2(2*SLOT_W)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic          o_bck,
    output logic          o_lrck,
    output logic          o_fe,
    output logic [BW-1:0] o_bit_nxt
);
    localparam int DW = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(BCK_HALF-1);
    localparam logic [BW-1:0] BIT_MAX = BW'(2*SLOT_W-1);
    localparam logic [BW-1:0] L_SLOT  = BW'(SLOT_W);

    logic [DW-1:0] r_div;
    logic          r_bck;
    logic          r_lrck;
    logic [BW-1:0] r_bit;
    logic          w_fe;
    logic [BW-1:0] w_bit_nxt;

    assign w_fe      = (r_div == DIV_MAX) && r_bck;
    assign w_bit_nxt = (r_bit == BIT_MAX) ? '0 : r_bit + 1'b1;

    // bit_cnt starts at the last position so the first falling edge opens frame 0
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div  <= '0;
            r_bck  <= 1'b0;
            r_lrck <= 1'b0;
            r_bit  <= BIT_MAX;
        end else begin
            if (r_div == DIV_MAX) begin
                r_div <= '0;
                r_bck <= ~r_bck;
            end else begin
                r_div <= r_div + 1'b1;
            end
            if (w_fe) begin
                r_bit  <= w_bit_nxt;
                r_lrck <= (w_bit_nxt >= L_SLOT);
            end
        end
    end

    assign o_bck     = r_bck;
    assign o_lrck    = r_lrck;
    assign o_fe      = w_fe;
    assign o_bit_nxt = w_bit_nxt;
endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter (clock master) for a PCM5102-class DAC: one-entry skid for
// incoming stereo pairs, frame latch at slot 0, MSB-first serialiser.
module i2s_tx #(
    parameter int SAMPLE_W = i2s_pkg::SAMPLE_W,
    parameter int SLOT_W   = i2s_pkg::SLOT_W,
    parameter int BCK_HALF = 2
) (
    input  logic                clk,
    input  logic                realReset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    output logic                bck,
    output logic                lrck,
    output logic                sdo,
    output logic                frame_start,
    output logic                underflow
);
    localparam int BW = $clog2(2*SLOT_W);
    localparam logic [BW-1:0] L_SLOT = BW'(SLOT_W);
    localparam logic [BW-1:0] L_SAMP = BW'(SAMPLE_W);

    logic                w_fe;
    logic [BW-1:0]       w_n;
    logic [BW-1:0]       w_pos;
    logic [SAMPLE_W-1:0] w_word;
    logic [SAMPLE_W-1:0] w_shift;
    logic                w_sdo_nxt;

    logic                r_skid_full;
    logic [SAMPLE_W-1:0] r_skid_l;
    logic [SAMPLE_W-1:0] r_skid_r;
    logic [SAMPLE_W-1:0] r_left;
    logic [SAMPLE_W-1:0] r_right;
    logic                r_sdo;
    logic                r_fs;
    logic                r_uf;

    i2s_clkgen #(
        .SLOT_W   (SLOT_W),
        .BCK_HALF (BCK_HALF)
    ) u_clkgen (
        .i_clk     (clk),
        .i_rst     (realReset),
        .o_bck     (bck),
        .o_lrck    (lrck),
        .o_fe      (w_fe),
        .o_bit_nxt (w_n)
    );

    // Slot position 0 is the I2S one-bit delay; data occupies positions 1..SAMPLE_W
    assign w_pos   = (w_n >= L_SLOT) ? w_n - L_SLOT : w_n;
    assign w_word  = (w_n < L_SLOT) ? r_left : r_right;
    assign w_shift = w_word << (w_pos - 1'b1);

    always_comb begin
        w_sdo_nxt = 1'b0;
        if ((w_pos != '0) && (w_pos <= L_SAMP))
            w_sdo_nxt = w_shift[SAMPLE_W-1];
    end

    always_ff @(posedge clk or posedge realReset) begin
        if (realReset) begin
            r_skid_full <= 1'b0;
            r_skid_l    <= '0;
            r_skid_r    <= '0;
            r_left      <= '0;
            r_right     <= '0;
            r_sdo       <= 1'b0;
            r_fs        <= 1'b0;
            r_uf        <= 1'b0;
        end else begin
            r_fs <= 1'b0;
            r_uf <= 1'b0;
            if (w_fe) begin
                r_sdo <= w_sdo_nxt;
                if (w_n == '0) begin
                    r_fs <= 1'b1;
                    if (r_skid_full) begin
                        r_left      <= r_skid_l;
                        r_right     <= r_skid_r;
                        r_skid_full <= 1'b0;
                    end else begin
                        r_left  <= '0;
                        r_right <= '0;
                        r_uf    <= 1'b1;
                    end
                end
            end
            // Accept only into an empty skid; a pair arriving on the load edge waits a frame
            if (in_valid && !r_skid_full) begin
                r_skid_l    <= in_left;
                r_skid_r    <= in_right;
                r_skid_full <= 1'b1;
            end
        end
    end

    assign in_ready    = !r_skid_full;
    assign sdo         = r_sdo;
    assign frame_start = r_fs;
    assign underflow   = r_uf;
endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: cycle-level behavioural model derived from elapsed clk count,
// plus directed captures of whole frames with literal expectations.
module tb_i2s_tx;
    localparam int SW = 24;
    localparam int SL = 32;
    localparam int BH = 2;
    localparam int FR = 2*SL*2*BH;

    logic          clk = 1'b0;
    logic          realReset = 1'b1;
    logic          in_valid = 1'b0;
    logic [SW-1:0] in_left = '0;
    logic [SW-1:0] in_right = '0;
    logic          in_ready, bck, lrck, sdo, frame_start, underflow;

    i2s_tx #(.SAMPLE_W(SW), .SLOT_W(SL), .BCK_HALF(BH)) dut (
        .clk(clk), .realReset(realReset), .in_valid(in_valid), .in_ready(in_ready),
        .in_left(in_left), .in_right(in_right), .bck(bck), .lrck(lrck), .sdo(sdo),
        .frame_start(frame_start), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model state: clk edges since reset release, pending pair, pair in current frame
    int            mk = 0;
    bit            m_full = 1'b0;
    logic [SW-1:0] m_pl = '0, m_pr = '0, m_cl = '0, m_cr = '0;
    bit            m_fs = 1'b0, m_uf = 1'b0;

    initial begin
        bit hs;
        int mm, n, p;
        logic eb, el, es;
        logic [SW-1:0] w;
        forever begin
            @(posedge clk or posedge realReset);
            if (realReset) begin
                mk = 0; m_full = 0; m_cl = '0; m_cr = '0; m_fs = 0; m_uf = 0;
            end else begin
                hs = in_valid && !m_full;
                mk++;
                m_fs = 0; m_uf = 0;
                if (mk % (2*BH) == 0 && ((mk/(2*BH)) - 1) % (2*SL) == 0) begin
                    m_fs = 1;
                    if (m_full) begin
                        m_cl = m_pl; m_cr = m_pr; m_full = 0;
                    end else begin
                        m_cl = '0; m_cr = '0; m_uf = 1;
                    end
                end
                if (hs) begin
                    m_pl = in_left; m_pr = in_right; m_full = 1;
                end
            end
            #1;
            eb = 1'((mk / BH) % 2);
            mm = mk / (2*BH);
            el = 1'b0; es = 1'b0;
            if (mm > 0) begin
                n  = (mm - 1) % (2*SL);
                el = (n >= SL);
                p  = n % SL;
                w  = el ? m_cr : m_cl;
                if (p >= 1 && p <= SW) es = w[SW-p];
            end
            chk("bck",         32'(bck),         32'(eb));
            chk("lrck",        32'(lrck),        32'(el));
            chk("sdo",         32'(sdo),         32'(es));
            chk("frame_start", 32'(frame_start), 32'(m_fs));
            chk("underflow",   32'(underflow),   32'(m_uf));
            chk("in_ready",    32'(in_ready),    32'(!m_full));
        end
    end

    // Wait for the next frame_start, then sample sdo on 64 bck rising edges
    task automatic capture(output logic [SW-1:0] l, output logic [SW-1:0] r,
                           output logic uf, output int bad);
        int t, i, p;
        logic pb;
        l = '0; r = '0; uf = 1'b0; bad = 0; t = 0;
        do begin
            @(posedge clk); #1; t++;
        end while (!frame_start && t < 600);
        if (!frame_start) begin
            bad = 999;
            return;
        end
        uf = underflow; pb = bck; i = 0; t = 0;
        while (i < 2*SL && t < 2000) begin
            @(posedge clk); #1; t++;
            if (bck && !pb) begin
                p = i % SL;
                if (p >= 1 && p <= SW) begin
                    if (i < SL) l[SW-p] = sdo;
                    else        r[SW-p] = sdo;
                end else if (sdo) begin
                    bad++;
                end
                if (lrck != (i >= SL)) bad++;
                i++;
            end
            pb = bck;
        end
        if (i < 2*SL) bad += 100;
    endtask

    initial begin
        logic [SW-1:0] cl, cr;
        logic cuf;
        int bad, t, acc;
        bit hs;

        // Idle after reset: silence with underflow on every frame
        repeat (3) @(negedge clk);
        realReset = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("fs_edge3", 32'(frame_start), 32'd0);
        @(posedge clk);
        #1 chk("fs_edge4", 32'(frame_start), 32'd1);
        chk("uf_edge4", 32'(underflow), 32'd1);
        t = 0;
        while (mk < 4 + FR + 10 && t < 1000) begin @(negedge clk); t++; end

        // Pair loaded before first frame
        @(negedge clk); realReset = 1'b1;
        repeat (2) @(negedge clk);
        realReset = 1'b0;
        in_valid = 1'b1; in_left = 24'hA5A5A5; in_right = 24'h5A5A5A;
        @(negedge clk); in_valid = 1'b0;
        capture(cl, cr, cuf, bad);
        chk("a5_left",  32'(cl),  32'h00A5A5A5);
        chk("a5_right", 32'(cr),  32'h005A5A5A);
        chk("a5_uf",    32'(cuf), 32'd0);
        chk("a5_pad",   32'(bad), 32'd0);

        // Stream 4 random pairs with valid held high
        acc = 0; t = 0;
        @(negedge clk);
        in_valid = 1'b1; in_left = 24'($urandom); in_right = 24'($urandom);
        while (acc < 4 && t < 3000) begin
            hs = in_ready;
            @(negedge clk); t++;
            if (hs) begin
                acc++;
                in_left = 24'($urandom); in_right = 24'($urandom);
            end
        end
        in_valid = 1'b0;
        chk("stream_accepted", 32'(acc), 32'd4);
        repeat (3*FR) @(negedge clk);

        // Handshake on the frame-load edge with an empty skid
        t = 0;
        while (!(((mk + 1) % FR == 2*BH) && !m_full) && t < 1000) begin @(negedge clk); t++; end
        chk("sim_reach", 32'(t < 1000), 32'd1);
        in_valid = 1'b1; in_left = 24'h800000; in_right = 24'h7FFFFF;
        @(posedge clk);
        #1 chk("sim_uf", 32'(underflow), 32'd1);
        chk("sim_fs", 32'(frame_start), 32'd1);
        chk("sim_ready", 32'(in_ready), 32'd0);
        @(negedge clk); in_valid = 1'b0;
        capture(cl, cr, cuf, bad);
        chk("sign_left",   32'(cl),     32'h00800000);
        chk("sign_right",  32'(cr),     32'h007FFFFF);
        chk("msb_left",    32'(cl[23]), 32'd1);
        chk("msb_right",   32'(cr[23]), 32'd0);
        chk("sign_uf",     32'(cuf),    32'd0);
        chk("sign_pad",    32'(bad),    32'd0);

        // Reset in the right slot with the skid full
        in_valid = 1'b1; in_left = 24'($urandom); in_right = 24'($urandom);
        t = 0;
        while (!(mk >= 4 && ((mk/(2*BH)) - 1) % (2*SL) == 40 && m_full) && t < 2000) begin
            @(negedge clk); t++;
        end
        chk("rst_reach", 32'(t < 2000), 32'd1);
        chk("rst_pre_ready", 32'(in_ready), 32'd0);
        chk("rst_pre_lrck",  32'(lrck),     32'd1);
        realReset = 1'b1; in_valid = 1'b0;
        #1;
        chk("rst_bck",   32'(bck),         32'd0);
        chk("rst_lrck",  32'(lrck),        32'd0);
        chk("rst_sdo",   32'(sdo),         32'd0);
        chk("rst_ready", 32'(in_ready),    32'd1);
        chk("rst_fs",    32'(frame_start), 32'd0);
        chk("rst_uf",    32'(underflow),   32'd0);
        repeat (3) @(negedge clk);
        realReset = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("post_rst_fs", 32'(frame_start), 32'd1);
        chk("post_rst_uf", 32'(underflow), 32'd1);
        repeat (FR + 20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
